// File: rtl/percent_display_ctrl_if.sv
// Purpose: bus between the progress computation and the percentage display
// sequencer. It carries the percentage strobe and value, the busy/overflow
// status, and the multiplexed digit bus (anodes plus BCD).
//   pct_valid : one-cycle strobe, pct_in is valid
//   pct_in    : percentage, nominal 0..100
//   busy      : conversion in progress
//   ovf       : last accepted value was saturated to 100
//   an        : active-low digit enables [0]=units [1]=tens [2]=hundreds
//   bcd_out   : BCD value of the selected digit
interface percent_display_ctrl_if;
  localparam int unsigned PCT_W = 8;
  localparam int unsigned AN_W  = 3;
  localparam int unsigned DIG_W = 4;

  logic             pct_valid;
  logic [PCT_W-1:0] pct_in;
  logic             busy;
  logic             ovf;
  logic [AN_W-1:0]  an;
  logic [DIG_W-1:0] bcd_out;

  // Producer side: the progress computation block
  modport master (
    output pct_valid, pct_in,
    input  busy, ovf, an, bcd_out
  );

  // Consumer side: the display sequencer
  modport slave (
    input  pct_valid, pct_in,
    output busy, ovf, an, bcd_out
  );
endinterface

// File: rtl/percent_display_ctrl.sv
// Purpose: captures a 0..100 percentage, converts it to hundreds/tens/units
// BCD by repeated subtraction (one subtraction per cycle), and time-
// multiplexes the three digits onto a shared BCD/anode bus with leading-zero
// blanking.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   disp  : percent_display_ctrl_if.slave (pct_valid/pct_in in,
//           busy/ovf/an/bcd_out out, all outputs registered)
// Parameter:
//   REFRESH_DIV : clk cycles each digit stays selected (>= 2)
module percent_display_ctrl #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  percent_display_ctrl_if.slave  disp
);

  localparam int unsigned PCT_W = 8;
  localparam int unsigned REM_W = 7;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned AN_W  = 3;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 2;

  localparam logic [PCT_W-1:0] PCT_MAX = PCT_W'(100);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_H = 2'd1,
    CONV_T = 2'd2,
    LOAD   = 2'd3
  } state_t;

  // Conversion state
  state_t           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [DIG_W-1:0] hcnt_q, hcnt_d;
  logic [DIG_W-1:0] tcnt_q, tcnt_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  // Displayed digits; only ever written together in LOAD
  logic [DIG_W-1:0] h_q, h_d;
  logic [DIG_W-1:0] t_q, t_d;
  logic [DIG_W-1:0] u_q, u_d;

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [AN_W-1:0]  an_q, an_d;
  logic [DIG_W-1:0] bcd_q, bcd_d;
  logic             wrap;

  // Conversion next-state and datapath
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hcnt_d  = hcnt_q;
    tcnt_d  = tcnt_q;
    ovf_d   = ovf_q;
    h_d     = h_q;
    t_d     = t_q;
    u_d     = u_q;

    unique case (state_q)
      IDLE: begin
        if (disp.pct_valid) begin
          if (disp.pct_in > PCT_MAX) begin
            rem_d = REM_W'(100);
            ovf_d = 1'b1;
          end else begin
            rem_d = disp.pct_in[REM_W-1:0];
            ovf_d = 1'b0;
          end
          hcnt_d  = '0;
          tcnt_d  = '0;
          state_d = CONV_H;
        end
      end
      CONV_H: begin
        if (rem_q >= REM_W'(100)) begin
          rem_d  = rem_q - REM_W'(100);
          hcnt_d = hcnt_q + DIG_W'(1);
        end else begin
          state_d = CONV_T;
        end
      end
      CONV_T: begin
        if (rem_q >= REM_W'(10)) begin
          rem_d  = rem_q - REM_W'(10);
          tcnt_d = tcnt_q + DIG_W'(1);
        end else begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        h_d     = hcnt_q;
        t_d     = tcnt_q;
        u_d     = rem_q[DIG_W-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy is registered alongside the state, so it tracks state != IDLE
    busy_d = (state_d != IDLE);
  end

  // Conversion registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      hcnt_q  <= '0;
      tcnt_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      h_q     <= '0;
      t_q     <= '0;
      u_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      h_q     <= h_d;
      t_q     <= t_d;
      u_q     <= u_d;
    end
  end

  // Refresh counter, scan index and next digit/anode selection
  always_comb begin
    wrap  = (cnt_q == (REFRESH_DIV - CNT_W'(1)));
    cnt_d = wrap ? '0 : (cnt_q + CNT_W'(1));
    idx_d = idx_q;
    an_d  = an_q;
    bcd_d = bcd_q;

    if (wrap) begin
      idx_d = (idx_q == IDX_W'(2)) ? '0 : (idx_q + IDX_W'(1));
      // Blanked slots keep bcd_out driven but leave every anode off
      unique case (idx_d)
        IDX_W'(0): begin
          an_d  = 3'b110;
          bcd_d = u_q;
        end
        IDX_W'(1): begin
          an_d  = ((h_q == '0) && (t_q == '0)) ? 3'b111 : 3'b101;
          bcd_d = t_q;
        end
        IDX_W'(2): begin
          an_d  = (h_q == '0) ? 3'b111 : 3'b011;
          bcd_d = h_q;
        end
        default: begin
          an_d  = 3'b111;
          bcd_d = '0;
        end
      endcase
    end
  end

  // Scan registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= 3'b110;
      bcd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      bcd_q <= bcd_d;
    end
  end

  assign disp.busy    = busy_q;
  assign disp.ovf     = ovf_q;
  assign disp.an      = an_q;
  assign disp.bcd_out = bcd_q;

endmodule

// File: tb/tb_percent_display_ctrl.sv
// Directed bench for percent_display_ctrl with a short refresh period.
module tb_percent_display_ctrl;

  localparam logic [15:0] DIV = 16'd4;
  localparam int unsigned LIMIT = 64;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  percent_display_ctrl_if disp ();

  percent_display_ctrl #(
    .REFRESH_DIV (DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (disp.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input int obs, input int exp_v, input string tag);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one percentage and measure how long busy stays high
  task automatic convert(input logic [7:0] p, input int exp_cyc,
                         input logic exp_ovf, input string tag);
    int n;
    disp.pct_valid = 1'b1;
    disp.pct_in    = p;
    step();
    disp.pct_valid = 1'b0;
    n = 0;
    while (disp.busy === 1'b1 && n < LIMIT) begin
      step();
      n++;
    end
    chk(n, exp_cyc, {tag, "_busy_cycles"});
    chk(int'(disp.ovf), int'(exp_ovf), {tag, "_ovf"});
  endtask

  // Sync to the start of a units slot, then check all three slots cycle by cycle
  task automatic check_scan(input logic [3:0] eu, input logic [3:0] et,
                            input logic [3:0] eh, input logic [2:0] an_t,
                            input logic [2:0] an_h, input string tag);
    int n;
    logic [2:0] exp_an [3];
    logic [3:0] exp_bcd [3];
    exp_an[0] = 3'b110; exp_bcd[0] = eu;
    exp_an[1] = an_t;   exp_bcd[1] = et;
    exp_an[2] = an_h;   exp_bcd[2] = eh;
    n = 0;
    while (disp.an === 3'b110 && n < LIMIT) begin
      step();
      n++;
    end
    while (disp.an !== 3'b110 && n < LIMIT) begin
      step();
      n++;
    end
    chk(int'(n < LIMIT), 1, {tag, "_sync_timeout"});
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < int'(DIV); c++) begin
        chk(int'(disp.an), int'(exp_an[s]), $sformatf("%s_an_s%0d_c%0d", tag, s, c));
        chk(int'(disp.bcd_out), int'(exp_bcd[s]), $sformatf("%s_bcd_s%0d_c%0d", tag, s, c));
        step();
      end
    end
  endtask

  initial begin
    int n;
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    disp.pct_valid = 1'b0;
    disp.pct_in    = 8'd0;

    // Reset values
    #12;
    chk(int'(disp.busy), 0, "rst_busy");
    chk(int'(disp.ovf), 0, "rst_ovf");
    chk(int'(disp.an), 3'b110, "rst_an");
    chk(int'(disp.bcd_out), 0, "rst_bcd");
    step();
    rst_n = 1'b1;
    step();

    // 49 -> 0/4/9, hundreds blanked
    convert(8'd49, 7, 1'b0, "p49");
    check_scan(4'd9, 4'd4, 4'd0, 3'b101, 3'b111, "p49");

    // 100 -> 1/0/0, tens zero shown
    convert(8'd100, 4, 1'b0, "p100");
    check_scan(4'd0, 4'd0, 4'd1, 3'b101, 3'b011, "p100");

    // 7 then 0: only units enabled
    convert(8'd7, 3, 1'b0, "p7");
    check_scan(4'd7, 4'd0, 4'd0, 3'b111, 3'b111, "p7");
    convert(8'd0, 3, 1'b0, "p0");
    check_scan(4'd0, 4'd0, 4'd0, 3'b111, 3'b111, "p0");

    // Saturation and ovf clear on next accept
    convert(8'd200, 4, 1'b1, "p200");
    check_scan(4'd0, 4'd0, 4'd1, 3'b101, 3'b011, "p200");
    convert(8'd50, 8, 1'b0, "p50");
    check_scan(4'd0, 4'd5, 4'd0, 3'b101, 3'b111, "p50");

    // Further values
    convert(8'd75, 10, 1'b0, "p75");
    check_scan(4'd5, 4'd7, 4'd0, 3'b101, 3'b111, "p75");
    convert(8'd101, 4, 1'b1, "p101");
    check_scan(4'd0, 4'd0, 4'd1, 3'b101, 3'b011, "p101");

    // 99 with a second strobe (50) while busy: must be dropped
    disp.pct_valid = 1'b1;
    disp.pct_in    = 8'd99;
    step();
    disp.pct_valid = 1'b0;
    n = 0;
    while (disp.busy === 1'b1 && n < LIMIT) begin
      if (n == 2) begin
        disp.pct_valid = 1'b1;
        disp.pct_in    = 8'd50;
      end else begin
        disp.pct_valid = 1'b0;
      end
      step();
      n++;
    end
    disp.pct_valid = 1'b0;
    chk(n, 12, "p99_busy_cycles");
    chk(int'(disp.busy), 0, "p99_no_requeue");
    check_scan(4'd9, 4'd9, 4'd0, 3'b101, 3'b111, "p99");

    // Reset in the middle of a conversion
    disp.pct_valid = 1'b1;
    disp.pct_in    = 8'd49;
    step();
    disp.pct_valid = 1'b0;
    step();
    chk(int'(disp.busy), 1, "midrst_busy_before");
    rst_n = 1'b0;
    #1;
    chk(int'(disp.busy), 0, "midrst_busy");
    chk(int'(disp.an), 3'b110, "midrst_an");
    chk(int'(disp.bcd_out), 0, "midrst_bcd");
    chk(int'(disp.ovf), 0, "midrst_ovf");
    step();
    rst_n = 1'b1;
    step();
    chk(int'(disp.busy), 0, "postrst_busy");
    check_scan(4'd0, 4'd0, 4'd0, 3'b111, 3'b111, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
